// File: rtl/vga_mem_arbiter.sv
// Single-port pixel RAM arbiter: display reads have strict priority, host writes
// are queued in a small FIFO and drained whenever the display is not fetching.
module vga_mem_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 1040
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        disp_req,
  input  logic [ADDR_W-1:0]           disp_addr,
  output logic [DATA_W-1:0]           disp_rdata,
  output logic                        disp_rvalid,
  input  logic                        host_valid,
  input  logic [ADDR_W-1:0]           host_addr,
  input  logic [DATA_W-1:0]           host_wdata,
  output logic                        host_ready,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        host_starved,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {IDLE, DISP, HOST} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]        fifo_addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0]        fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0]        fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic                     mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]        mem_wdata_q, mem_wdata_d;
  logic                     rd_pipe_q, rd_pipe_d;
  logic                     disp_rvalid_q, disp_rvalid_d;
  logic [DATA_W-1:0]        disp_rdata_q, disp_rdata_d;
  logic [CNT_W-1:0]         starve_cnt_q, starve_cnt_d;
  logic                     host_starved_q, host_starved_d;
  logic                     push, pop;

  // Pop uses the pre-push level, so a word pushed into an empty FIFO waits a cycle.
  assign host_ready = rst && (level_q < LVL_W'(FIFO_DEPTH));
  assign push       = host_valid && host_ready;
  assign pop        = !disp_req && (level_q != '0);

  always_comb begin
    fifo_addr_d    = fifo_addr_q;
    fifo_data_d    = fifo_data_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q;
    state_d        = IDLE;
    mem_en_d       = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_d     = '0;
    mem_wdata_d    = '0;
    starve_cnt_d   = starve_cnt_q;

    if (push) begin
      fifo_addr_d[wr_ptr_q] = host_addr;
      fifo_data_d[wr_ptr_q] = host_wdata;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end

    if (disp_req) begin
      state_d    = DISP;
      mem_en_d   = 1'b1;
      mem_addr_d = disp_addr;
    end else if (pop) begin
      state_d     = HOST;
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = fifo_addr_q[rd_ptr_q];
      mem_wdata_d = fifo_data_q[rd_ptr_q];
    end

    // Counts consecutive cycles where queued work sits without being drained.
    if (pop || level_q == '0) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_W'(STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
    host_starved_d = host_starved_q || (starve_cnt_d == CNT_W'(STARVE_LIM));

    rd_pipe_d     = (state_q == DISP);
    disp_rvalid_d = rd_pipe_q;
    disp_rdata_d  = rd_pipe_q ? mem_rdata : disp_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      fifo_addr_q    <= '{default: '0};
      fifo_data_q    <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      rd_pipe_q      <= 1'b0;
      disp_rvalid_q  <= 1'b0;
      disp_rdata_q   <= '0;
      starve_cnt_q   <= '0;
      host_starved_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fifo_addr_q    <= fifo_addr_d;
      fifo_data_q    <= fifo_data_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      rd_pipe_q      <= rd_pipe_d;
      disp_rvalid_q  <= disp_rvalid_d;
      disp_rdata_q   <= disp_rdata_d;
      starve_cnt_q   <= starve_cnt_d;
      host_starved_q <= host_starved_d;
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign disp_rvalid  = disp_rvalid_q;
  assign disp_rdata   = disp_rdata_q;
  assign host_starved = host_starved_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed testbench for vga_mem_arbiter: vector table for per-cycle arbitration
// plus hand sequences for FIFO fill, display contention, starvation and reset.
module tb_vga_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_req;
  logic [18:0] disp_addr;
  logic [11:0] disp_rdata;
  logic        disp_rvalid;
  logic        host_valid;
  logic [18:0] host_addr;
  logic [11:0] host_wdata;
  logic        host_ready;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic        host_starved;
  logic [2:0]  fifo_level;

  int assertions = 0;
  int failures   = 0;

  logic [11:0] ram [0:4095];

  vga_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .host_valid(host_valid), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .host_starved(host_starved), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // RAM model: read data valid one clock after the read is presented.
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr[11:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[11:0]];
  end

  typedef struct {
    logic        dreq;
    logic [18:0] daddr;
    logic        hv;
    logic [18:0] haddr;
    logic [11:0] hdata;
    logic        en;
    logic        we;
    logic [18:0] maddr;
    logic [11:0] mwdata;
    logic        rdy;
    logic [2:0]  lvl;
    logic        rv;
    logic [11:0] rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    disp_req   = v.dreq;
    disp_addr  = v.daddr;
    host_valid = v.hv;
    host_addr  = v.haddr;
    host_wdata = v.hdata;
  endtask

  initial begin
    int idx;
    int wr_seen;
    int bad;
    logic acc;

    for (int i = 0; i < 4096; i++) ram[i] = '0;
    ram[12'h123] = 12'hF00;
    ram[12'h010] = 12'hABC;
    ram[12'h011] = 12'h456;
    mem_rdata = '0;

    //          dreq daddr     hv haddr     hdata   en we maddr     mwdata  rdy lvl rv rdata
    vecs[0]  = '{0, 19'h0,     0, 19'h0,    12'h0,   0, 0, 19'h0,   12'h0,   1, 0, 0, 12'h0};
    vecs[1]  = '{1, 19'h123,   0, 19'h0,    12'h0,   1, 0, 19'h123, 12'h0,   1, 0, 0, 12'h0};
    vecs[2]  = '{0, 19'h0,     0, 19'h0,    12'h0,   0, 0, 19'h0,   12'h0,   1, 0, 0, 12'h0};
    vecs[3]  = '{0, 19'h0,     0, 19'h0,    12'h0,   0, 0, 19'h0,   12'h0,   1, 0, 1, 12'hF00};
    vecs[4]  = '{0, 19'h0,     1, 19'h200,  12'h111, 0, 0, 19'h0,   12'h0,   1, 1, 0, 12'h0};
    vecs[5]  = '{0, 19'h0,     0, 19'h0,    12'h0,   1, 1, 19'h200, 12'h111, 1, 0, 0, 12'h0};
    vecs[6]  = '{1, 19'h010,   1, 19'h201,  12'h222, 1, 0, 19'h010, 12'h0,   1, 1, 0, 12'h0};
    vecs[7]  = '{1, 19'h011,   1, 19'h202,  12'h333, 1, 0, 19'h011, 12'h0,   1, 2, 0, 12'h0};
    vecs[8]  = '{0, 19'h0,     1, 19'h203,  12'h444, 1, 1, 19'h201, 12'h222, 1, 2, 1, 12'hABC};
    vecs[9]  = '{0, 19'h0,     0, 19'h0,    12'h0,   1, 1, 19'h202, 12'h333, 1, 1, 1, 12'h456};
    vecs[10] = '{0, 19'h0,     0, 19'h0,    12'h0,   1, 1, 19'h203, 12'h444, 1, 0, 0, 12'h0};
    vecs[11] = '{0, 19'h0,     0, 19'h0,    12'h0,   0, 0, 19'h0,   12'h0,   1, 0, 0, 12'h0};

    rst = 1'b0;
    disp_req = 0; disp_addr = '0; host_valid = 0; host_addr = '0; host_wdata = '0;
    repeat (3) tick();
    checkOutput("reset_mem_en", 32'(mem_en), 0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 0);
    checkOutput("reset_rvalid", 32'(disp_rvalid), 0);
    checkOutput("reset_level", 32'(fifo_level), 0);
    checkOutput("reset_host_ready", 32'(host_ready), 0);
    checkOutput("reset_starved", 32'(host_starved), 0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].en));
      checkOutput($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].we));
      if (vecs[i].en)
        checkOutput($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
      if (vecs[i].we)
        checkOutput($sformatf("vec%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].mwdata));
      checkOutput($sformatf("vec%0d_host_ready", i), 32'(host_ready), 32'(vecs[i].rdy));
      checkOutput($sformatf("vec%0d_fifo_level", i), 32'(fifo_level), 32'(vecs[i].lvl));
      checkOutput($sformatf("vec%0d_rvalid", i), 32'(disp_rvalid), 32'(vecs[i].rv));
      if (vecs[i].rv)
        checkOutput($sformatf("vec%0d_rdata", i), 32'(disp_rdata), 32'(vecs[i].rdata));
    end

    // Host fill: five back-to-back pushes drain one per cycle, never back-pressured.
    disp_req = 0;
    for (int k = 0; k < 6; k++) begin
      host_valid = (k < 5);
      host_addr  = 19'h400 + 19'(k);
      host_wdata = 12'h500 + 12'(k);
      if (k < 5) checkOutput($sformatf("fill%0d_host_ready", k), 32'(host_ready), 1);
      tick();
      if (k == 0) begin
        checkOutput("fill0_mem_en", 32'(mem_en), 0);
      end else begin
        checkOutput($sformatf("fill%0d_mem_we", k), 32'(mem_we), 1);
        checkOutput($sformatf("fill%0d_mem_addr", k), 32'(mem_addr), 32'h400 + 32'(k - 1));
        checkOutput($sformatf("fill%0d_mem_wdata", k), 32'(mem_wdata), 32'h500 + 32'(k - 1));
      end
    end
    host_valid = 0;
    tick();
    checkOutput("fill_level_end", 32'(fifo_level), 0);
    checkOutput("fill_ram_last", 32'(ram[12'h404]), 32'h504);

    // Contention: display holds the RAM, host queue fills and stalls.
    idx = 0;
    wr_seen = 0;
    for (int c = 0; c < 800; c++) begin
      disp_req   = 1;
      disp_addr  = 19'h300;
      host_valid = (idx < 6);
      host_addr  = 19'h600 + 19'(idx);
      host_wdata = 12'h700 + 12'(idx);
      acc = host_valid && host_ready;
      tick();
      if (acc) idx++;
      if (mem_we) wr_seen++;
      if (c == 3) begin
        checkOutput("cont_host_ready_full", 32'(host_ready), 0);
        checkOutput("cont_level_full", 32'(fifo_level), 4);
      end
    end
    checkOutput("cont_accepted", 32'(idx), 4);
    checkOutput("cont_no_writes", 32'(wr_seen), 0);
    checkOutput("cont_not_starved", 32'(host_starved), 0);
    for (int j = 0; j < 6; j++) begin
      disp_req   = 0;
      host_valid = (idx < 6);
      host_addr  = 19'h600 + 19'(idx);
      host_wdata = 12'h700 + 12'(idx);
      acc = host_valid && host_ready;
      tick();
      if (acc) idx++;
      checkOutput($sformatf("drain%0d_mem_we", j), 32'(mem_we), 1);
      checkOutput($sformatf("drain%0d_mem_addr", j), 32'(mem_addr), 32'h600 + 32'(j));
      checkOutput($sformatf("drain%0d_mem_wdata", j), 32'(mem_wdata), 32'h700 + 32'(j));
    end
    host_valid = 0;
    checkOutput("drain_accepted", 32'(idx), 6);
    checkOutput("drain_level_end", 32'(fifo_level), 0);

    // Starvation: one word queued behind a continuous display burst.
    disp_req   = 1;
    disp_addr  = 19'h300;
    host_valid = 1;
    host_addr  = 19'h800;
    host_wdata = 12'h900;
    tick();
    host_valid = 0;
    for (int n = 1; n <= 1100; n++) begin
      tick();
      if (n == 1039) checkOutput("starve_before_lim", 32'(host_starved), 0);
      if (n == 1040) checkOutput("starve_at_lim", 32'(host_starved), 1);
    end
    checkOutput("starve_level_held", 32'(fifo_level), 1);
    disp_req = 0;
    tick();
    checkOutput("starve_drain_we", 32'(mem_we), 1);
    checkOutput("starve_drain_addr", 32'(mem_addr), 32'h800);
    tick();
    checkOutput("starve_sticky", 32'(host_starved), 1);
    checkOutput("starve_level_end", 32'(fifo_level), 0);

    // Reset one cycle after a read request with a write queued.
    disp_req   = 1;
    disp_addr  = 19'h123;
    host_valid = 1;
    host_addr  = 19'hA00;
    host_wdata = 12'hBBB;
    tick();
    disp_req   = 0;
    host_valid = 0;
    rst        = 0;
    #1;
    checkOutput("rstmid_mem_en", 32'(mem_en), 0);
    checkOutput("rstmid_level", 32'(fifo_level), 0);
    checkOutput("rstmid_host_ready", 32'(host_ready), 0);
    checkOutput("rstmid_starved", 32'(host_starved), 0);
    repeat (2) tick();
    rst = 1;
    bad = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (disp_rvalid || mem_en || fifo_level != 0) bad++;
    end
    checkOutput("rstmid_quiet_after_release", 32'(bad), 0);
    checkOutput("rstmid_ram_untouched", 32'(ram[12'hA00]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
